spi_xfer_sched: RTL and testbench
=================================

SPI_XFER_SCHED -- requirements
Module: spi_xfer_sched

Interface
REQ-001 SHALL have parameter SPI_BASE, default 32'hffff0010, meaning base address of the SPI peripheral (DATA=+0, CTRL=+4, STAT=+8).
REQ-002 SHALL have parameter CPOL, default 0, meaning clock-polarity bit written to CTRL[1].
REQ-003 SHALL have parameter CPHA, default 0, meaning clock-phase bit written to CTRL[2].
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of POLL cycles per byte before abort.
REQ-005 SHALL have ports clk input 1 (clock) and rst input 1 (reset, asynchronous, active-low).
REQ-006 SHALL have ports req input 2, per-requester transfer request, level-held until its last byte completes.
REQ-007 SHALL have ports gnt output 2, one-hot grant, all zero when no owner.
REQ-008 SHALL have ports tx_valid input 2, tx_last input 2, and tx_data input 16 (requester i on bits [8i+7:8i]), per-requester byte stream.
REQ-009 SHALL have port tx_ready output 2, one-cycle pulse when the owner's byte is accepted.
REQ-010 SHALL have ports rx_valid output 1, rx_data output 8, and rx_id output 1: received byte, one-cycle valid, tagged with the owner index.
REQ-011 SHALL have port err output 1, one-cycle pulse on a timeout abort.
REQ-012 SHALL have ports bus_we output 1, bus_addr output 32, bus_wdata output 32, and bus_rdata input 32, a master port to the SPI peripheral; rdata is combinational and valid in the same cycle when bus_we=0.

Function
REQ-013 SHALL implement FSM states IDLE, WR_DATA, WR_CTRL, WAIT_BUSY, POLL, RD_DATA, and NEXT.
REQ-014 In IDLE, with any req bit set, SHALL grant round-robin: the requester not granted last wins on ties, and requester 0 is favoured after reset; gnt asserts on the cycle after the decision and holds until release.
REQ-015 SHALL, when entering WR_DATA with owner tx_valid=1: drive bus_we=1, addr=SPI_BASE+0, wdata={24'b0,tx_data}, pulse tx_ready, and latch tx_last.
REQ-016 SHALL stay in WR_DATA with bus_we=0 when the owner has tx_valid=0, with no timeout counting.
REQ-017 In WR_CTRL, SHALL drive bus_we=1, addr=SPI_BASE+4, and wdata={28'b0, 1'b0, CPHA, CPOL, 1'b1} for exactly one cycle.
REQ-018 In WAIT_BUSY, SHALL read SPI_BASE+8 and wait for bus_rdata[0]=1 (the peripheral reports busy with at least one cycle of lag), then go to POLL; this wait SHALL be bounded by the same TIMEOUT counter.
REQ-019 In POLL, SHALL read SPI_BASE+8 each cycle and go to RD_DATA on the first cycle with bus_rdata[0]=0.
REQ-020 In RD_DATA, SHALL read SPI_BASE+0, drive rx_data=bus_rdata[7:0], rx_id=owner, and rx_valid=1 for one cycle.
REQ-021 NEXT SHALL go to WR_DATA when the latched tx_last=0; otherwise it SHALL clear gnt and return to IDLE.
REQ-022 Grant SHALL never change mid-transfer; a req deassertion mid-transfer SHALL be ignored until the latched tx_last byte finishes.
REQ-023 The timeout counter SHALL be 32 bits, cleared on entry to WAIT_BUSY, and saturating; reaching TIMEOUT SHALL pulse err, write CTRL=0, clear gnt, return to IDLE without rx_valid, and flip priority away from the aborted owner.
REQ-024 When not writing, SHALL drive bus_we=0, bus_wdata=0, and bus_addr=SPI_BASE+8 (a harmless STAT read).
REQ-025 Per byte, the bus transaction order SHALL be exactly DATA write, CTRL write, STAT reads, DATA read, with no other accesses interleaved.
REQ-026 If tx_valid and tx_last both arrive in the grant cycle, SHALL produce a single-byte transfer.
REQ-027 Simultaneous req with both bits set SHALL yield exactly one gnt bit; gnt SHALL never have both bits set.

Reset
REQ-028 While rst=0, SHALL hold state=IDLE, gnt=0, tx_ready=0, rx_valid=0, rx_data=0, rx_id=0, err=0, bus_we=0, bus_wdata=0, bus_addr=SPI_BASE+8, priority pointer=requester 0, and timeout counter=0.
REQ-029 Reset asserted mid-transfer SHALL abort immediately without a CTRL write, and the first post-reset grant SHALL follow REQ-014.

Verification
REQ-030 Single byte: req=01, tx_data=8'hA5, tx_last=1, peripheral model busy 18 cycles returning 8'h3C -> writes DATA=0xA5, then CTRL=0x1; rx_valid with rx_data=8'h3C, rx_id=0; gnt returns to 0.
REQ-031 Contention: req=11 from reset -> gnt=01 first; after its last byte gnt=10; a repeated req=11 -> gnt=01 (alternation).
REQ-032 Three-byte burst: requester 1 sends 0x11, 0x22, 0x33 (last on 0x33) -> three DATA/CTRL/STAT/DATA sequences in order, three rx_valid pulses with rx_id=1, and gnt never drops between bytes.
REQ-033 Stall: owner tx_valid low for 50 cycles between bytes -> no bus writes, no err, and transfer completes afterwards.
REQ-034 Timeout: TIMEOUT=16 with STAT stuck busy -> err pulse 16 cycles after POLL entry, CTRL written 0, gnt=0, no rx_valid.
REQ-035 Reset mid-POLL -> all outputs at REQ-028 values asynchronously; a new req=10 is granted normally.

Source files
------------

// File: rtl/spi_xfer_sched.sv
// Two-requester SPI transfer scheduler.
// Arbitrates round-robin between two byte streams and drives a memory-mapped
// SPI peripheral through DATA write, CTRL write, STAT polling and DATA read
// for every byte. Each STAT wait is bounded by a saturating timeout counter.
module spi_xfer_sched #(
  parameter logic [31:0] SPI_BASE = 32'hffff0010,
  parameter bit          CPOL     = 1'b0,
  parameter bit          CPHA     = 1'b0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  tx_valid,
  input  logic [1:0]  tx_last,
  input  logic [15:0] tx_data,
  output logic [1:0]  tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_id,
  output logic        err,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [31:0] DATA_ADDR = SPI_BASE;
  localparam logic [31:0] CTRL_ADDR = SPI_BASE + 32'd4;
  localparam logic [31:0] STAT_ADDR = SPI_BASE + 32'd8;
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_CTRL, WAIT_BUSY, POLL, RD_DATA, NEXT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        prio_q, prio_d;
  logic [31:0] cnt_q, cnt_d;

  logic        owner_valid;
  logic        owner_last;
  logic [7:0]  owner_byte;
  logic        stat_busy;
  logic        timeout_hit;
  logic [31:0] cnt_inc;
  logic        winner;
  logic        unused_rdata;

  assign owner_valid  = tx_valid[owner_q];
  assign owner_last   = tx_last[owner_q];
  assign owner_byte   = owner_q ? tx_data[15:8] : tx_data[7:0];
  assign stat_busy    = bus_rdata[0];
  assign timeout_hit  = (cnt_q >= TMO_LIMIT);
  assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  assign winner       = (req == 2'b11) ? prio_q : req[1];
  assign unused_rdata = ^bus_rdata[31:8];
  assign gnt          = gnt_q;

  // State and datapath registers; reset lands in IDLE with requester 0 favoured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitration, byte sequencing and timeout abort.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = winner;
          gnt_d   = winner ? 2'b10 : 2'b01;
          prio_d  = ~winner;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (owner_valid) begin
          last_d  = owner_last;
          state_d = WR_CTRL;
        end
      end
      WR_CTRL: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, POLL: begin
        // Counter restarts on POLL entry so the poll phase alone gets the full budget.
        if (timeout_hit) begin
          gnt_d   = '0;
          prio_d  = ~owner_q;
          state_d = IDLE;
        end else if ((state_q == WAIT_BUSY) && stat_busy) begin
          cnt_d   = '0;
          state_d = POLL;
        end else if ((state_q == POLL) && !stat_busy) begin
          state_d = RD_DATA;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RD_DATA: state_d = NEXT;
      NEXT: begin
        if (last_q) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = WR_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: bus master strobes and requester handshakes decoded from state.
  always_comb begin
    tx_ready  = '0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    rx_id     = 1'b0;
    err       = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = STAT_ADDR;
    bus_wdata = '0;
    unique case (state_q)
      WR_DATA: begin
        if (owner_valid) begin
          bus_we            = 1'b1;
          bus_addr          = DATA_ADDR;
          bus_wdata         = {24'b0, owner_byte};
          tx_ready[owner_q] = 1'b1;
        end
      end
      WR_CTRL: begin
        bus_we    = 1'b1;
        bus_addr  = CTRL_ADDR;
        bus_wdata = {28'b0, 1'b0, CPHA, CPOL, 1'b1};
      end
      WAIT_BUSY, POLL: begin
        if (timeout_hit) begin
          err      = 1'b1;
          bus_we   = 1'b1;
          bus_addr = CTRL_ADDR;
        end
      end
      RD_DATA: begin
        bus_addr = DATA_ADDR;
        rx_valid = 1'b1;
        rx_data  = bus_rdata[7:0];
        rx_id    = owner_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: peripheral model, bus-order monitor, table and
// randomized transfers against a round-robin reference, plus corner sequences.
module tb_spi_xfer_sched;
  localparam logic [31:0] BASE     = 32'hffff0010;
  localparam logic [31:0] BASE2    = 32'h40000000;
  localparam logic [31:0] CTRL_EXP = 32'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req, gnt, tx_valid, tx_last, tx_ready;
  logic [15:0] tx_data;
  logic        rx_valid, rx_id, err, bus_we;
  logic [7:0]  rx_data;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  logic [1:0]  req2, gnt2, tx_valid2, tx_last2, tx_ready2;
  logic [15:0] tx_data2;
  logic        rx_valid2, unused_rx_id2, err2, bus_we2;
  logic [7:0]  unused_rx_data2;
  logic [31:0] bus_addr2, bus_wdata2, bus_rdata2;

  spi_xfer_sched u_dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_id(rx_id), .err(err),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  spi_xfer_sched #(.SPI_BASE(BASE2), .CPOL(1'b1), .CPHA(1'b1), .TIMEOUT(16)) u_dut_to (
    .clk(clk), .rst(rst), .req(req2), .gnt(gnt2),
    .tx_valid(tx_valid2), .tx_last(tx_last2), .tx_data(tx_data2), .tx_ready(tx_ready2),
    .rx_valid(rx_valid2), .rx_data(unused_rx_data2), .rx_id(unused_rx_id2), .err(err2),
    .bus_we(bus_we2), .bus_addr(bus_addr2), .bus_wdata(bus_wdata2), .bus_rdata(bus_rdata2)
  );

  assign bus_rdata2 = 32'h1;  // STAT stuck busy

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Peripheral model: busy appears one cycle after the CTRL start and lasts p_busy cycles;
  // DATA read returns the last written byte XOR 0x99.
  int          p_busy = 4;
  int          pcnt;
  logic [7:0]  pdata;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt  <= 0;
      pdata <= 8'h00;
    end else begin
      if (m_we && m_addr == BASE) pdata <= m_wdata[7:0];
      if (m_we && m_addr == BASE + 32'd4) pcnt <= m_wdata[0] ? p_busy + 1 : 0;
      else if (pcnt > 0) pcnt <= pcnt - 1;
    end
  end

  assign bus_rdata = (bus_addr == BASE + 32'd8) ? {31'b0, (pcnt >= 1 && pcnt <= p_busy)} :
                     (bus_addr == BASE) ? {24'b0, pdata ^ 8'h99} : 32'h0;

  // Bus monitor: each byte must be DATA write, CTRL write, STAT reads, DATA read.
  int ph = 0;
  int n_wr = 0;
  int n_err = 0;
  always @(negedge clk) begin
    m_we = bus_we; m_addr = bus_addr; m_wdata = bus_wdata;
    if (!rst) ph = 0;
    else begin
      if (bus_we) begin
        n_wr++;
        if (bus_addr == BASE) begin
          check("order_data_wr", ph, 0);
          ph = 1;
        end else begin
          check("ctrl_addr", bus_addr, BASE + 32'd4);
          check("order_ctrl_wr", ph, 1);
          check("ctrl_value", bus_wdata, CTRL_EXP);
          ph = 2;
        end
      end else begin
        if (ph == 1) check("ctrl_follows_data", {31'b0, bus_we}, 1);
        check("idle_wdata", bus_wdata, 0);
        if (rx_valid) begin
          check("order_rx", ph, 2);
          check("rx_addr", bus_addr, BASE);
          ph = 0;
        end else check("stat_addr", bus_addr, BASE + 32'd8);
      end
      if (err) n_err++;
    end
  end

  logic [7:0] xb [8];

  task automatic run_xfer(input logic [1:0] rq, input logic [1:0] eg, input int n, input int stall);
    int own, t, w0;
    bit gbad;
    @(posedge clk); #1;
    req = rq;
    t = 0;
    @(negedge clk);
    while (gnt == 2'b00 && t < 20) begin @(posedge clk); #1; @(negedge clk); t++; end
    check("grant", gnt, eg);
    own = eg[1] ? 1 : 0;
    gbad = 0;
    for (int b = 0; b < n; b++) begin
      if (b > 0 && stall > 0) begin
        w0 = n_wr;
        repeat (stall) begin @(posedge clk); #1; @(negedge clk); if (gnt !== eg) gbad = 1; end
        check("stall_no_write", n_wr, w0);
      end
      @(posedge clk); #1;
      tx_valid[own] = 1'b1;
      tx_last[own]  = (b == n - 1);
      tx_data[own*8 +: 8] = xb[b];
      t = 0;
      @(negedge clk);
      while (!tx_ready[own] && t < 20) begin @(posedge clk); #1; @(negedge clk); t++; end
      check("tx_ready", tx_ready[own], 1);
      check("data_wr", bus_wdata, {24'b0, xb[b]});
      @(posedge clk); #1;
      tx_valid = '0; tx_last = '0;
      t = 0;
      @(negedge clk);
      while (!rx_valid && t < 100) begin
        if (gnt !== eg) gbad = 1;
        @(posedge clk); #1; @(negedge clk); t++;
      end
      check("rx_data", rx_data, xb[b] ^ 8'h99);
      check("rx_id", rx_id, own);
      if (b == n - 1) begin @(posedge clk); #1; req = '0; end
    end
    check("gnt_held", gbad, 0);
    t = 0;
    @(negedge clk);
    while (gnt != 2'b00 && t < 10) begin @(posedge clk); #1; @(negedge clk); t++; end
    check("gnt_release", gnt, 0);
  endtask

  typedef struct {
    logic [1:0] rq;
    logic [1:0] eg;
    int         n;
    int         busy;
    logic [7:0] d0;
  } vec_t;

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    vec_t tbl [7];
    int last_win, d, e, t, w0, win, n, stall;
    logic [31:0] ctrlv;
    logic [1:0] rq, eg;
    bit rxs, rdy;

    tbl[0] = '{2'b11, 2'b01, 1, 4,  8'h10};
    tbl[1] = '{2'b11, 2'b10, 2, 3,  8'h20};
    tbl[2] = '{2'b11, 2'b01, 1, 7,  8'h30};
    tbl[3] = '{2'b10, 2'b10, 1, 2,  8'h40};
    tbl[4] = '{2'b01, 2'b01, 3, 1,  8'h50};
    tbl[5] = '{2'b11, 2'b10, 2, 9,  8'h60};
    tbl[6] = '{2'b01, 2'b01, 1, 18, 8'hA5};

    req = '0; tx_valid = '0; tx_last = '0; tx_data = '0;
    req2 = '0; tx_valid2 = '0; tx_last2 = '0; tx_data2 = '0;

    // Reset values
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_err", err, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_addr", bus_addr, BASE + 32'd8);
    @(negedge clk); rst = 1'b1;

    // Timeout abort on the stuck-busy instance
    @(posedge clk); #1;
    req2 = 2'b01; tx_valid2 = 2'b01; tx_last2 = 2'b01; tx_data2 = 16'h0077;
    d = -1; e = -1; rxs = 0; ctrlv = '1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      rdy = tx_ready2[0];
      if (bus_we2 && bus_addr2 == BASE2 && d < 0) d = k;
      if (d >= 0 && k == d + 1) ctrlv = bus_we2 ? bus_wdata2 : 32'hdead;
      if (rx_valid2) rxs = 1;
      if (err2 && e < 0) begin
        e = k;
        check("to_ctrl_we", bus_we2, 1);
        check("to_ctrl_addr", bus_addr2, BASE2 + 32'd4);
        check("to_ctrl_zero", bus_wdata2, 0);
      end
      if (e >= 0 && k == e + 1) check("to_gnt_clear", gnt2, 0);
      @(posedge clk); #1;
      if (rdy) begin tx_valid2 = '0; tx_last2 = '0; end
      if (e >= 0) req2 = '0;
    end
    check("to_latency", 32'(e - d), 19);
    check("to_ctrl_cpol_cpha", ctrlv, 32'h7);
    check("to_no_rx", rxs, 0);
    req2 = 2'b11;
    @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    check("to_prio_flip", gnt2, 2'b10);
    @(posedge clk); #1; req2 = '0;

    // Table-driven arbitration / transfer vectors
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < tbl[i].n; k++) xb[k] = tbl[i].d0 + 8'(k * 17);
      p_busy = tbl[i].busy;
      run_xfer(tbl[i].rq, tbl[i].eg, tbl[i].n, 0);
    end
    last_win = 0;

    // Three-byte burst from requester 1
    xb[0] = 8'h11; xb[1] = 8'h22; xb[2] = 8'h33; p_busy = 6;
    run_xfer(2'b10, 2'b10, 3, 0);
    last_win = 1;

    // 50-cycle stall between bytes
    xb[0] = 8'h81; xb[1] = 8'h82; p_busy = 3;
    run_xfer(2'b01, 2'b01, 2, 50);
    last_win = 0;

    // tx_valid and tx_last present in the grant cycle
    @(posedge clk); #1;
    req = 2'b01; tx_valid = 2'b01; tx_last = 2'b01; tx_data = 16'h005A; w0 = n_wr;
    @(negedge clk);
    check("g26_gnt_decide", gnt, 0);
    @(posedge clk); #1; @(negedge clk);
    check("g26_gnt", gnt, 2'b01);
    check("g26_tx_ready", tx_ready, 2'b01);
    check("g26_we", bus_we, 1);
    check("g26_wdata", bus_wdata, 32'h5A);
    @(posedge clk); #1; tx_valid = '0; tx_last = '0;
    t = 0; @(negedge clk);
    while (!rx_valid && t < 100) begin @(posedge clk); #1; @(negedge clk); t++; end
    check("g26_rx", rx_data, 8'h5A ^ 8'h99);
    @(posedge clk); #1; req = '0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check("g26_gnt_release", gnt, 0);
    check("g26_two_writes", n_wr - w0, 2);

    // Randomized transfers against the round-robin reference
    for (int i = 0; i < 20; i++) begin
      rq = 2'($urandom_range(1, 3));
      n = $urandom_range(1, 4);
      stall = $urandom_range(0, 3);
      p_busy = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) xb[k] = 8'($urandom);
      win = (rq == 2'b11) ? 1 - last_win : (rq == 2'b10 ? 1 : 0);
      last_win = win;
      eg = (win == 1) ? 2'b10 : 2'b01;
      run_xfer(rq, eg, n, stall);
    end
    check("no_err_main", n_err, 0);

    // Reset during POLL, then a fresh request from requester 1
    p_busy = 100;
    @(posedge clk); #1;
    req = 2'b01; tx_valid = 2'b01; tx_last = 2'b01; tx_data = 16'h0042;
    repeat (2) @(posedge clk);
    #1; tx_valid = '0; tx_last = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("r35_in_poll_gnt", gnt, 2'b01);
    check("r35_in_poll_addr", bus_addr, BASE + 32'd8);
    @(posedge clk); #3;
    rst = 1'b0; req = '0;
    #1;
    check("r35_gnt", gnt, 0);
    check("r35_tx_ready", tx_ready, 0);
    check("r35_rx_valid", rx_valid, 0);
    check("r35_rx_data", rx_data, 0);
    check("r35_rx_id", rx_id, 0);
    check("r35_err", err, 0);
    check("r35_we", bus_we, 0);
    check("r35_wdata", bus_wdata, 0);
    check("r35_addr", bus_addr, BASE + 32'd8);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    p_busy = 4; xb[0] = 8'h5C;
    run_xfer(2'b10, 2'b10, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
